// File: rtl/frame_stat_pkg.sv
// Shared types and constants for the frame statistics block.
package frame_stat_pkg;

  // Receive FSM states.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRE,
    ST_PAY,
    ST_DROP
  } state_t;

  // Register map.
  localparam logic [15:0] ADDR_CTRL        = 16'h0020;
  localparam logic [15:0] ADDR_MIN_LEN     = 16'h0021;
  localparam logic [15:0] ADDR_MAX_LEN     = 16'h0022;
  localparam logic [15:0] ADDR_GOOD_CNT    = 16'h0023;
  localparam logic [15:0] ADDR_LEN_ERR_CNT = 16'h0024;
  localparam logic [15:0] ADDR_PRE_ERR_CNT = 16'h0025;
  localparam logic [15:0] ADDR_LAST_LEN    = 16'h0026;
  localparam logic [15:0] ADDR_LAST_SUM    = 16'h0027;

  // Frame delimiters.
  localparam logic [7:0] PREAMBLE = 8'h55;
  localparam logic [7:0] SFD      = 8'hD5;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/frame_stat_sat_cnt16.sv
// 16-bit saturating event counter; clear wins over increment.
module sat_cnt16
  import frame_stat_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        clr,
  output logic [15:0] count
);

  // Count events, clear on request, hold at 0xFFFF.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= 16'd0;
    end else if (inc) begin
      count <= sat_inc16(count);
    end
  end

endmodule

// File: rtl/frame_stat.sv
// Frame classifier: strips preamble/SFD, measures payload length and
// byte sum, counts good / length-error / preamble-error frames, and
// exposes everything through a small register bus.
module frame_stat
  import frame_stat_pkg::*;
#(
  parameter logic [15:0] MIN_LEN_RST = 16'd4,
  parameter logic [15:0] MAX_LEN_RST = 16'd64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_dv,
  input  logic [7:0]  rxd,
  input  logic        bus_cmd_valid,
  input  logic        bus_op,
  input  logic [15:0] bus_addr,
  input  logic [15:0] bus_wr_data,
  output logic [15:0] bus_rd_data,
  output logic        frame_done,
  output logic        frame_ok
);

  state_t      state_reg, state_next;
  logic        rx_dv_prev;
  logic        enable_reg;
  logic [15:0] min_len_reg, max_len_reg;
  logic [15:0] len_reg, sum_reg;
  logic [15:0] last_len_reg, last_sum_reg;
  logic [15:0] good_cnt, len_err_cnt, pre_err_cnt;
  logic        frame_end, pre_err, len_good;
  logic        wr_en, rd_en;
  logic [15:0] rd_mux;

  assign wr_en    = bus_cmd_valid && bus_op;
  assign rd_en    = bus_cmd_valid && !bus_op;
  assign len_good = (min_len_reg <= len_reg) && (len_reg <= max_len_reg);

  // Previous rx_dv, left out of reset so a frame still running across a
  // reset release is not mistaken for a new rising edge.
  always_ff @(posedge clk) begin
    rx_dv_prev <= rx_dv;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Next state plus end-of-frame and preamble-error events.
  always_comb begin
    state_next = state_reg;
    frame_end  = 1'b0;
    pre_err    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (enable_reg && rx_dv && !rx_dv_prev) state_next = ST_PRE;
      end
      ST_PRE: begin
        if (!rx_dv) begin
          state_next = ST_IDLE;
          pre_err    = 1'b1;
        end else if (rxd == SFD) begin
          state_next = ST_PAY;
        end else if (rxd != PREAMBLE) begin
          state_next = ST_DROP;
          pre_err    = 1'b1;
        end
      end
      ST_PAY: begin
        if (!rx_dv) begin
          state_next = ST_IDLE;
          frame_end  = 1'b1;
        end
      end
      ST_DROP: begin
        if (!rx_dv) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Payload length and sum accumulation; restart on SFD.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_reg <= 16'd0;
      sum_reg <= 16'd0;
    end else if (state_reg == ST_PRE && rx_dv && rxd == SFD) begin
      len_reg <= 16'd0;
      sum_reg <= 16'd0;
    end else if (state_reg == ST_PAY && rx_dv) begin
      len_reg <= sat_inc16(len_reg);
      sum_reg <= sum_reg + {8'd0, rxd};
    end
  end

  // Latch the finished frame's results and pulse the classification.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_len_reg <= 16'd0;
      last_sum_reg <= 16'd0;
      frame_done   <= 1'b0;
      frame_ok     <= 1'b0;
    end else begin
      frame_done <= frame_end;
      frame_ok   <= frame_end && len_good;
      if (frame_end) begin
        last_len_reg <= len_reg;
        last_sum_reg <= sum_reg;
      end
    end
  end

  // Writable configuration registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enable_reg  <= 1'b0;
      min_len_reg <= MIN_LEN_RST;
      max_len_reg <= MAX_LEN_RST;
    end else if (wr_en) begin
      if (bus_addr == ADDR_CTRL)    enable_reg  <= bus_wr_data[0];
      if (bus_addr == ADDR_MIN_LEN) min_len_reg <= bus_wr_data;
      if (bus_addr == ADDR_MAX_LEN) max_len_reg <= bus_wr_data;
    end
  end

  sat_cnt16 u_good_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (frame_end && len_good),
    .clr   (wr_en && bus_addr == ADDR_GOOD_CNT),
    .count (good_cnt)
  );

  sat_cnt16 u_len_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (frame_end && !len_good),
    .clr   (wr_en && bus_addr == ADDR_LEN_ERR_CNT),
    .count (len_err_cnt)
  );

  sat_cnt16 u_pre_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pre_err),
    .clr   (wr_en && bus_addr == ADDR_PRE_ERR_CNT),
    .count (pre_err_cnt)
  );

  // Read-data selection; unmapped addresses return zero.
  always_comb begin
    rd_mux = 16'd0;
    case (bus_addr)
      ADDR_CTRL:        rd_mux = {15'd0, enable_reg};
      ADDR_MIN_LEN:     rd_mux = min_len_reg;
      ADDR_MAX_LEN:     rd_mux = max_len_reg;
      ADDR_GOOD_CNT:    rd_mux = good_cnt;
      ADDR_LEN_ERR_CNT: rd_mux = len_err_cnt;
      ADDR_PRE_ERR_CNT: rd_mux = pre_err_cnt;
      ADDR_LAST_LEN:    rd_mux = last_len_reg;
      ADDR_LAST_SUM:    rd_mux = last_sum_reg;
      default:          rd_mux = 16'd0;
    endcase
  end

  // Registered read data, held between reads.
  always_ff @(posedge clk) begin
    if (!rst_n)     bus_rd_data <= 16'd0;
    else if (rd_en) bus_rd_data <= rd_mux;
  end

endmodule

// File: tb/tb_frame_stat.sv
// Randomized + directed bench for frame_stat against a frame-level model.
module tb_frame_stat;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_dv;
  logic [7:0]  rxd;
  logic        bus_cmd_valid;
  logic        bus_op;
  logic [15:0] bus_addr;
  logic [15:0] bus_wr_data;
  logic [15:0] bus_rd_data;
  logic        frame_done;
  logic        frame_ok;

  always #5 clk = ~clk;

  frame_stat #(.MIN_LEN_RST(16'd4), .MAX_LEN_RST(16'd64)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_dv         (rx_dv),
    .rxd           (rxd),
    .bus_cmd_valid (bus_cmd_valid),
    .bus_op        (bus_op),
    .bus_addr      (bus_addr),
    .bus_wr_data   (bus_wr_data),
    .bus_rd_data   (bus_rd_data),
    .frame_done    (frame_done),
    .frame_ok      (frame_ok)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // frame_done monitor
  int   done_cnt = 0;
  logic last_ok  = 1'b0;
  always @(negedge clk) begin
    if (frame_done === 1'b1) begin
      done_cnt++;
      last_ok = frame_ok;
    end
  end

  // reference model state
  bit          m_en;
  logic [15:0] m_min, m_max, m_good, m_lerr, m_perr, m_last_len, m_last_sum;

  function automatic logic [15:0] sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic model_reset();
    m_en = 0; m_min = 16'd4; m_max = 16'd64;
    m_good = 0; m_lerr = 0; m_perr = 0; m_last_len = 0; m_last_sum = 0;
  endtask

  // frame stimulus
  bit [7:0] fbuf[$];
  int       en_at;
  bit       clr_good;

  // kind: 0 ignored, 1 preamble error, 2 classified payload frame
  task automatic predict(output int kind, output logic [15:0] len, output logic [15:0] sum);
    int i;
    len = 0; sum = 0;
    if (!m_en) begin
      kind = 0;
      return;
    end
    i = 1;  // the byte that starts the frame is not inspected
    while (i < fbuf.size() && fbuf[i] == 8'h55) i++;
    if (i >= fbuf.size() || fbuf[i] != 8'hD5) begin
      kind = 1;
      return;
    end
    kind = 2;
    for (int j = i + 1; j < fbuf.size(); j++) begin
      len = len + 16'd1;
      sum = sum + {8'd0, fbuf[j]};
    end
  endtask

  task automatic drive_frame();
    for (int i = 0; i < fbuf.size(); i++) begin
      @(negedge clk);
      bus_cmd_valid = 0;
      rx_dv = 1; rxd = fbuf[i];
      if (i == en_at) begin
        bus_cmd_valid = 1; bus_op = 1; bus_addr = 16'h0020; bus_wr_data = 16'd1;
      end
    end
    @(negedge clk);
    rx_dv = 0; rxd = 0; bus_cmd_valid = 0;
    if (clr_good) begin
      bus_cmd_valid = 1; bus_op = 1; bus_addr = 16'h0023; bus_wr_data = 16'hFFFF;
    end
    @(negedge clk);
    bus_cmd_valid = 0;
    @(negedge clk);
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    @(negedge clk);
    bus_cmd_valid = 1; bus_op = 0; bus_addr = a;
    @(negedge clk);
    bus_cmd_valid = 0;
    d = bus_rd_data;
  endtask

  task automatic reg_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    bus_cmd_valid = 1; bus_op = 1; bus_addr = a; bus_wr_data = d;
    @(negedge clk);
    bus_cmd_valid = 0;
    case (a)
      16'h0020: m_en = d[0];
      16'h0021: m_min = d;
      16'h0022: m_max = d;
      16'h0023: m_good = 0;
      16'h0024: m_lerr = 0;
      16'h0025: m_perr = 0;
      default: ;
    endcase
    $display("write addr=%04h data=%04h", a, d);
  endtask

  task automatic check_regs(input string tag);
    logic [15:0] d;
    bus_read(16'h0020, d); check({tag, "_ctrl"}, d, {15'd0, m_en});
    bus_read(16'h0021, d); check({tag, "_min"}, d, m_min);
    bus_read(16'h0022, d); check({tag, "_max"}, d, m_max);
    bus_read(16'h0023, d); check({tag, "_good"}, d, m_good);
    bus_read(16'h0024, d); check({tag, "_lenerr"}, d, m_lerr);
    bus_read(16'h0025, d); check({tag, "_preerr"}, d, m_perr);
    bus_read(16'h0026, d); check({tag, "_lastlen"}, d, m_last_len);
    bus_read(16'h0027, d); check({tag, "_lastsum"}, d, m_last_sum);
  endtask

  task automatic run_frame(input string tag, input bit full_check);
    int kind, d0;
    logic [15:0] len, sum;
    bit exp_ok;
    predict(kind, len, sum);
    exp_ok = (kind == 2) && (m_min <= len) && (len <= m_max);
    d0 = done_cnt;
    drive_frame();
    check({tag, "_done"}, done_cnt - d0, (kind == 2) ? 1 : 0);
    if (kind == 2) check({tag, "_ok"}, {31'd0, last_ok}, {31'd0, exp_ok});
    if (kind == 2) begin
      m_last_len = len; m_last_sum = sum;
      if (exp_ok) m_good = sat(m_good);
      else        m_lerr = sat(m_lerr);
    end else if (kind == 1) begin
      m_perr = sat(m_perr);
    end
    if (clr_good) m_good = 0;
    if (en_at >= 0) m_en = 1;
    $display("frame %s bytes=%0d kind=%0d len=%0d sum=%04h ok=%0d", tag, fbuf.size(), kind, len, sum, exp_ok);
    en_at = -1; clr_good = 0;
    if (full_check) check_regs(tag);
  endtask

  task automatic good_frame(input int plen);
    fbuf.delete();
    repeat (3) fbuf.push_back(8'h55);
    fbuf.push_back(8'hD5);
    for (int i = 0; i < plen; i++) fbuf.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    logic [15:0] d;
    rst_n = 0; rx_dv = 0; rxd = 0;
    bus_cmd_valid = 0; bus_op = 0; bus_addr = 0; bus_wr_data = 0;
    en_at = -1; clr_good = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_rd_data", bus_rd_data, 16'd0);
    check("rst_done", {31'd0, frame_done}, 32'd0);
    check("rst_ok", {31'd0, frame_ok}, 32'd0);
    rst_n = 1;
    check_regs("reset");
    bus_read(16'h0000, d); check("unmapped_00", d, 16'd0);
    bus_read(16'h0028, d); check("unmapped_28", d, 16'd0);

    // disabled frame must be ignored
    good_frame(5);
    run_frame("disabled", 1);

    reg_write(16'h0020, 16'd1);
    fbuf = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5,
             8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run_frame("good5", 1);
    check("good5_lastlen_c", m_last_len, 16'd5);
    check("good5_lastsum_c", m_last_sum, 16'h000F);

    fbuf = '{8'h55, 8'hD5, 8'hAA, 8'hBB};
    run_frame("short2", 1);
    check("short2_sum_c", m_last_sum, 16'h0165);

    fbuf = '{8'h55, 8'h12, 8'h34};
    run_frame("badpre", 1);
    fbuf = '{8'h55, 8'h55};
    run_frame("nosfd", 1);
    check("nosfd_pre_c", m_perr, 16'd2);

    // clear coinciding with classification
    good_frame(6);
    clr_good = 1;
    run_frame("clr_same", 1);

    // enable raised mid-frame: frame ignored
    reg_write(16'h0020, 16'd0);
    good_frame(6);
    en_at = 4;
    run_frame("en_mid", 1);

    // reset in the middle of a payload
    fbuf = '{8'h55, 8'hD5, 8'h11, 8'h22};
    for (int i = 0; i < fbuf.size(); i++) begin
      @(negedge clk); rx_dv = 1; rxd = fbuf[i];
    end
    begin
      int d0;
      d0 = done_cnt;
      @(negedge clk); rst_n = 0; rxd = 8'h33;
      @(negedge clk); rxd = 8'h44;
      @(negedge clk); rst_n = 1; rxd = 8'h55;
      @(negedge clk); rxd = 8'h66;
      @(negedge clk); rx_dv = 0; rxd = 0;
      repeat (2) @(negedge clk);
      model_reset();
      check("rstmid_done", done_cnt - d0, 32'd0);
    end
    check_regs("rstmid");
    reg_write(16'h0020, 16'd1);
    good_frame(5);
    run_frame("after_rst", 1);
    reg_write(16'h0021, 16'd3);
    reg_write(16'h0022, 16'd3);
    good_frame(3);
    run_frame("eq3", 1);
    good_frame(4);
    run_frame("eq3_len4", 1);

    // min > max: always a length error
    reg_write(16'h0021, 16'd6);
    reg_write(16'h0022, 16'd2);
    good_frame(4);
    run_frame("inverted", 1);

    // read-only register ignores writes; read data holds
    reg_write(16'h0026, 16'h1234);
    reg_write(16'h0027, 16'h5678);
    check_regs("ro");
    bus_read(16'h0021, d);
    reg_write(16'h0022, 16'd64);
    repeat (2) @(negedge clk);
    check("rd_hold", bus_rd_data, m_min);
    reg_write(16'h0021, 16'd2);

    // randomized frames and register traffic
    for (int n = 0; n < 150; n++) begin
      int r;
      string tag;
      r = $urandom_range(0, 19);
      if (r == 0) reg_write(16'h0021, 16'($urandom_range(0, 10)));
      else if (r == 1) reg_write(16'h0022, 16'($urandom_range(0, 12)));
      else if (r == 2) reg_write(16'h0020, 16'($urandom_range(0, 1)));
      else if (r == 3) reg_write(16'h0024, 16'd0);
      else if (r == 4) reg_write(16'h0025, 16'd0);
      fbuf.delete();
      fbuf.push_back(8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 3)) fbuf.push_back(8'h55);
      r = $urandom_range(0, 9);
      if (r < 7) begin
        fbuf.push_back(8'hD5);
        repeat ($urandom_range(0, 9)) fbuf.push_back(8'($urandom_range(0, 255)));
      end else if (r < 9) begin
        repeat ($urandom_range(1, 3)) fbuf.push_back(8'($urandom_range(0, 255)));
      end
      clr_good = ($urandom_range(0, 9) == 0);
      tag = $sformatf("rnd%0d", n);
      run_frame(tag, (n % 5) == 4);
    end
    check_regs("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
